rr_onehot_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 10 +
 rtl/rr_pick.sv | 27 ++
 rtl/rr_onehot_arbiter.sv | 83 ++++++++
 tb/tb_rr_onehot_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and state type for the round-robin one-hot arbiter
//   NREQ  - number of requesters (one-hot grant width)
//   IDXW  - width of the encoded grant index
//   HOLDW - width of the saturating hold counter
package arb_pkg;
    localparam int NREQ  = 8;
    localparam int IDXW  = 3;
    localparam int HOLDW = 8;
    typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner search starting at ptr
//   req    in  - request vector
//   ptr    in  - first index to search (last holder + 1)
//   valid  out - any request present
//   idx    out - winning index
//   onehot out - winning index as one-hot
module rr_pick import arb_pkg::*; (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic            valid,
    output logic [IDXW-1:0] idx,
    output logic [NREQ-1:0] onehot
);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDXW-1:0]   off;
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NREQ-1:0];
        off = '0;
        // descending scan leaves the lowest set bit of the rotated vector
        for (int i = NREQ - 1; i >= 0; i--) off = rot[i] ? IDXW'(i) : off;
        valid  = |req;
        idx    = ptr + off;
        onehot = NREQ'(1) << idx;
    end
endmodule

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: registered round-robin arbiter with hold limit for an 8-way one-hot resource
//   arb_clk     in  - clock
//   arb_rst     in  - synchronous active-high reset
//   arb_req     in  - request vector
//   arb_done    in  - holder releases the grant
//   arb_gnt     out - registered one-hot grant (or zero)
//   arb_gnt_idx out - encoded grant index, held while idle
//   arb_busy    out - grant active
//   arb_timeout out - one-cycle pulse when the hold limit revokes a grant
module rr_onehot_arbiter import arb_pkg::*; #(
    parameter int MAX_HOLD = 16
) (
    input  logic            arb_clk,
    input  logic            arb_rst,
    input  logic [NREQ-1:0] arb_req,
    input  logic            arb_done,
    output logic [NREQ-1:0] arb_gnt,
    output logic [IDXW-1:0] arb_gnt_idx,
    output logic            arb_busy,
    output logic            arb_timeout
);
    localparam logic [HOLDW-1:0] LIMIT = HOLDW'(MAX_HOLD);
    state_t            state_q, state_d;
    logic [IDXW-1:0]   ptr_q, ptr_d, idx_q, idx_d, pick_idx;
    logic [HOLDW-1:0]  hold_q, hold_d;
    logic [NREQ-1:0]   gnt_q, gnt_d, pick_oh;
    logic              tmo_q, tmo_d, pick_valid, hit, rel;
    rr_pick u_pick (
        .req    (arb_req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        tmo_d   = 1'b0;
        hit     = (MAX_HOLD != 0) && (hold_q == LIMIT);
        rel     = arb_done || !arb_req[idx_q] || hit;
        if (state_q == IDLE) begin
            if (pick_valid) begin
                state_d = GRANT;
                gnt_d   = pick_oh;
                idx_d   = pick_idx;
                hold_d  = HOLDW'(1);
            end
        end else if (rel) begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = idx_q + IDXW'(1);
            hold_d  = '0;
            // an explicit release on the expiry cycle is a normal release
            tmo_d   = hit && !arb_done;
        end else begin
            hold_d = (hold_q == '1) ? hold_q : hold_q + HOLDW'(1);
        end
    end
    always_ff @(posedge arb_clk) begin
        if (arb_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            tmo_q   <= tmo_d;
        end
    end
    assign arb_gnt     = gnt_q;
    assign arb_gnt_idx = idx_q;
    assign arb_busy    = (state_q == GRANT);
    assign arb_timeout = tmo_q;
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb_rr_onehot_arbiter: directed self-checking bench for rr_onehot_arbiter with MAX_HOLD = 4
module tb_rr_onehot_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gidx;
    logic       busy, tmo;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [2:0] exp_idx = '0;

    rr_onehot_arbiter #(.MAX_HOLD(4)) dut (
        .arb_clk     (clk),
        .arb_rst     (rst),
        .arb_req     (req),
        .arb_done    (done),
        .arb_gnt     (gnt),
        .arb_gnt_idx (gidx),
        .arb_busy    (busy),
        .arb_timeout (tmo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // expected index follows the last nonzero expected grant
    task automatic expect_out(input string tag, input logic [7:0] g, input logic t);
        for (int i = 0; i < 8; i++) if (g[i]) exp_idx = 3'(i);
        chk({tag, ".gnt"}, gnt, g);
        chk({tag, ".idx"}, {5'b0, gidx}, {5'b0, exp_idx});
        chk({tag, ".busy"}, {7'b0, busy}, {7'b0, |g});
        chk({tag, ".tmo"}, {7'b0, tmo}, {7'b0, t});
    endtask

    initial begin
        step();
        expect_out("rst1", 8'h00, 1'b0);
        step();
        expect_out("rst2", 8'h00, 1'b0);
        rst = 1'b0;
        req = 8'h08;
        step();
        expect_out("single", 8'h08, 1'b0);
        done = 1'b1;
        step();
        expect_out("single_rel", 8'h00, 1'b0);
        done = 1'b0;
        req = 8'h00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_idx = 3'd0;
        expect_out("rst3", 8'h00, 1'b0);
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            expect_out($sformatf("rr%0d", k), 8'h01 << (k % 8), 1'b0);
            done = 1'b1;
            step();
            expect_out($sformatf("rr_gap%0d", k), 8'h00, 1'b0);
            done = 1'b0;
        end
        req = 8'h40;
        step();
        expect_out("h6", 8'h40, 1'b0);
        done = 1'b1;
        step();
        expect_out("h6_rel", 8'h00, 1'b0);
        done = 1'b0;
        req = 8'h05;
        step();
        expect_out("wrap0", 8'h01, 1'b0);
        done = 1'b1;
        step();
        expect_out("wrap0_rel", 8'h00, 1'b0);
        done = 1'b0;
        step();
        expect_out("wrap2", 8'h04, 1'b0);
        req = 8'h03;
        step();
        expect_out("wrap2_drop", 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            expect_out($sformatf("hold0_%0d", k), 8'h01, 1'b0);
        end
        step();
        expect_out("timeout", 8'h00, 1'b1);
        step();
        expect_out("hold1_0", 8'h02, 1'b0);
        for (int k = 1; k < 4; k++) begin
            step();
            expect_out($sformatf("hold1_%0d", k), 8'h02, 1'b0);
        end
        done = 1'b1;
        step();
        expect_out("done_vs_limit", 8'h00, 1'b0);
        done = 1'b0;
        step();
        expect_out("regrant0", 8'h01, 1'b0);
        step();
        expect_out("regrant0_b", 8'h01, 1'b0);
        req = 8'h02;
        step();
        expect_out("req_drop", 8'h00, 1'b0);
        step();
        expect_out("g1", 8'h02, 1'b0);
        req = 8'hFE;
        step();
        expect_out("g1_others", 8'h02, 1'b0);
        req = 8'h00;
        step();
        expect_out("g1_rel", 8'h00, 1'b0);
        req = 8'h20;
        step();
        expect_out("h5", 8'h20, 1'b0);
        rst = 1'b1;
        req = 8'h21;
        step();
        exp_idx = 3'd0;
        expect_out("rst_mid", 8'h00, 1'b0);
        rst = 1'b0;
        step();
        expect_out("post_rst", 8'h01, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
